// File: rtl/pc_sequencer_if.sv
// Bundle between the control unit/ALU/memories and the PC sequencer.
// Optional INSTR_COUNT signal exists only when PC_INSTR_COUNT_EN is defined.
interface pc_sequencer_if;
  // BUSYWAIT has stall semantics, not valid/ready: while it is high at a rising
  // edge the PC does not advance. A redirect seen in the first busy cycle is held
  // and applied at the first edge that samples BUSYWAIT low.
  logic        BUSYWAIT;
  logic        JUMP;
  logic        BRANCH;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic [31:0] PC;
  logic        FETCH_EN;
  logic        STALLED;
  logic [1:0]  STATE;
  logic        PEND;
`ifdef PC_INSTR_COUNT_EN
  logic [31:0] INSTR_COUNT;
`endif

  modport master (
    output BUSYWAIT, JUMP, BRANCH, ZERO, OFFSET,
    input  PC, FETCH_EN, STALLED, STATE, PEND
`ifdef PC_INSTR_COUNT_EN
    , input INSTR_COUNT
`endif
  );

  modport slave (
    input  BUSYWAIT, JUMP, BRANCH, ZERO, OFFSET,
    output PC, FETCH_EN, STALLED, STATE, PEND
`ifdef PC_INSTR_COUNT_EN
    , output INSTR_COUNT
`endif
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC register and next-PC selection (PC+4, jump, taken branch) with stall hold.
// Define PC_INSTR_COUNT_EN to add the retired-instruction counter INSTR_COUNT.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RESET,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_tgt;
  logic        fetch_en;
  logic        stalled;

  logic [31:0] seq;
  logic [31:0] tgt;
  logic [31:0] offset_bytes;
  logic        redirect;
  logic [31:0] next_pc;

`ifdef PC_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  // OFFSET is a signed word offset; scale to bytes after sign extension.
  always_comb begin
    seq          = pc + 32'd4;
    offset_bytes = {{22{bus.OFFSET[7]}}, bus.OFFSET, 2'b00};
    tgt          = seq + offset_bytes;
    redirect     = bus.JUMP | (bus.BRANCH & bus.ZERO);
    next_pc      = redirect ? tgt : seq;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      pend     <= 1'b0;
      pend_tgt <= 32'h0000_0000;
      fetch_en <= 1'b0;
      stalled  <= 1'b0;
`ifdef PC_INSTR_COUNT_EN
      instr_count <= 32'h0000_0000;
`endif
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          fetch_en <= 1'b1;
          stalled  <= 1'b0;
        end
        RUN: begin
          fetch_en <= 1'b1;
          if (bus.BUSYWAIT) begin
            // Capture the outcome now; control inputs are ignored until release.
            pend     <= 1'b1;
            pend_tgt <= next_pc;
            state    <= STALL;
            stalled  <= 1'b1;
          end else begin
            pc      <= next_pc;
            stalled <= 1'b0;
`ifdef PC_INSTR_COUNT_EN
            instr_count <= instr_count + 32'd1;
`endif
          end
        end
        STALL: begin
          fetch_en <= 1'b1;
          if (!bus.BUSYWAIT) begin
            pc      <= pend_tgt;
            pend    <= 1'b0;
            state   <= RUN;
            stalled <= 1'b0;
`ifdef PC_INSTR_COUNT_EN
            instr_count <= instr_count + 32'd1;
`endif
          end
        end
        default: begin
          state    <= BOOT;
          pc       <= RESET_PC;
          pend     <= 1'b0;
          fetch_en <= 1'b0;
          stalled  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC       = pc;
  assign bus.FETCH_EN = fetch_en;
  assign bus.STALLED  = stalled;
  assign bus.STATE    = state;
  assign bus.PEND     = pend;
`ifdef PC_INSTR_COUNT_EN
  assign bus.INSTR_COUNT = instr_count;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 8-bit single-cycle processor. It owns the PC register and selects each next PC: sequential increment by 4, unconditional jump, or taken branch. It freezes the PC while instruction or data memory asserts busy-wait, and holds a redirect that arrives during a stall until the stall clears. It sits between the control unit/ALU (JUMP, BRANCH, ZERO, OFFSET) and instruction memory (PC, FETCH_EN).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- BUSYWAIT  input  1  memory stall request; PC must hold while high.
- JUMP  input  1  unconditional redirect for the current instruction.
- BRANCH  input  1  conditional redirect, taken when ZERO=1.
- ZERO  input  1  ALU zero flag for the current instruction.
- OFFSET  input  8  signed word offset from the instruction.
- PC  output  32  current fetch address.
- FETCH_EN  output  1  instruction memory may fetch at PC.
- STALLED  output  1  sequencer is in STALL.
- INSTR_COUNT  output  32  retired-instruction count; present only with PC_INSTR_COUNT_EN.

## Operation
- States: BOOT, RUN, STALL.
- Reset: PC=RESET_PC, state=BOOT, pend=0, pend_tgt=0, FETCH_EN=0, STALLED=0, INSTR_COUNT=0.
- Arithmetic, all modulo 2^32:
  - seq = PC + 4.
  - tgt = seq + (sign_extend_32(OFFSET) << 2).
  - redirect = JUMP | (BRANCH & ZERO).
  - next = redirect ? tgt : seq.
- BOOT:
  - FETCH_EN=0, PC held.
  - Unconditional transition to RUN. The first fetch occurs at RESET_PC.
- RUN, BUSYWAIT=0: PC<=next; stay in RUN.
- RUN, BUSYWAIT=1:
  - PC held; pend<=1; pend_tgt<=next; go to STALL.
  - The target is captured in the first busy cycle. Control inputs are ignored for the rest of the stall.
- STALL, BUSYWAIT=1: hold PC, pend and pend_tgt.
- STALL, BUSYWAIT=0: PC<=pend_tgt; pend<=0; go to RUN.
- FETCH_EN=1 in RUN and STALL. STALLED=1 only in STALL.
- Simultaneous events:
  - RESET overrides everything, including a mid-stall pending redirect, which is discarded.
  - JUMP and BRANCH both high is treated as a redirect; both produce the same tgt.
- BRANCH=1 with ZERO=0 selects seq.
- Wrap-around: PC=32'hFFFF_FFFC advances to 32'h0000_0000 with no flag. A tgt that underflows also wraps silently.

## Timing
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Sequential or redirect latency: the new PC is visible 1 cycle after the edge at which the instruction executes with BUSYWAIT=0.
- Stall latency: with BUSYWAIT high for N cycles, PC holds for N+1 cycles. It updates at the first edge that samples BUSYWAIT=0 in STALL.
- After RESET deasserts: 1 BOOT cycle, then the first RUN cycle, both at PC=RESET_PC.
- BUSYWAIT is sampled only at rising edges. Glitches between edges have no effect.

## Configuration
- PC_INSTR_COUNT_EN defined:
  - Adds the INSTR_COUNT port, a 32-bit counter.
  - Counts +1 at every edge where PC updates, i.e. RUN with BUSYWAIT=0, or STALL exit.
  - Wraps modulo 2^32; reset clears it to 0.
- Undefined: INSTR_COUNT port and counter are absent; all other behaviour is identical.

## Test plan
- Reset/boot: RESET high 2 cycles, then low, no redirects -> PC=0, FETCH_EN=0 for 1 cycle, then PC sequence 0,4,8,12 with FETCH_EN=1.
- Taken branch: PC=8, BRANCH=1, ZERO=1, OFFSET=8'hFE -> PC=4. Repeat with ZERO=0 -> PC=12.
- Jump during stall: PC=0x10, JUMP=1, OFFSET=3, BUSYWAIT high 3 cycles; JUMP drops after the first busy cycle.
  - Required: PC=0x10 held for 4 cycles and STALLED high for 3 cycles.
  - Then PC=0x20; with the macro, INSTR_COUNT rises by 1 only.
- Wrap-around: force PC to 32'hFFFF_FFFC with no redirect -> PC=0. JUMP with OFFSET=8'h80 at PC=0 -> PC=32'hFFFF_FE04.
- Reset mid-stall: RESET asserted in STALL with pend=1 -> PC=RESET_PC, state BOOT, STALLED=0. The pending target is never applied.
- Counter (macro defined): 5 sequential instructions plus 1 stalled instruction -> INSTR_COUNT=6. The stall cycles do not count.
